// File: rtl/simplez_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous memory.
// Latency: grant edge + 2 cycles to a one-cycle ack; waiting requests hold until acked, never preempt.
module simplez_mem_arbiter #(
    parameter int AW = 9,
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rw,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_win;
    logic          r_last;
    logic          r_we;
    logic          r_ack0;
    logic          r_ack1;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;
    logic          w_elig0;
    logic          w_elig1;
    logic          w_grant;
    logic          w_win;

    // A port whose ack is still high is finishing; ignoring it stops a held req being served twice.
    assign w_elig0 = req0 & ~r_ack0;
    assign w_elig1 = req1 & ~r_ack1;

    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        w_win   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_elig0 || w_elig1) begin
                    w_grant = 1'b1;
                    w_next  = ACCESS;
                    w_win   = (w_elig0 && w_elig1) ? ~r_last : w_elig1;
                end
            end
            ACCESS:  w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_win   <= 1'b0;
            r_last  <= 1'b1;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
        end else begin
            if (w_grant) begin
                r_win   <= w_win;
                r_last  <= w_win;
                r_we    <= w_win ? we1 : we0;
                r_addr  <= w_win ? addr1 : addr0;
                r_wdata <= w_win ? wdata1 : wdata0;
            end
            // mem_dout reflects the address presented during ACCESS by the time we reach DONE.
            if (r_state == DONE && !r_we) begin
                r_rdata <= mem_dout;
            end
            r_ack0 <= (r_state == DONE) && !r_win;
            r_ack1 <= (r_state == DONE) &&  r_win;
        end
    end

    assign ack0     = r_ack0;
    assign ack1     = r_ack1;
    assign rdata    = r_rdata;
    assign busy     = (r_state != IDLE);
    assign mem_addr = r_addr;
    assign mem_din  = r_wdata;
    assign mem_rw   = !((r_state == ACCESS) && r_we);

endmodule
